// File: rtl/tff_bank.sv
// tff_bank: WIDTH-bit register of T-flop cells (q ^= t) used as a toggle bank or as an up/down counter.
// Define TFF_BANK_SAT_EN to make the counter modes saturate at their limit instead of wrapping.
module tff_bank #(
  parameter int               WIDTH   = 8,
  parameter int               MODE    = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               CLK_POL = 1'b1
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic             L,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] Q,
  output logic             TC
);

  localparam bit IS_UP   = (MODE == 1);
  localparam bit IS_DOWN = (MODE == 2);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH:0]   ones_chain;
  logic [WIDTH:0]   zeros_chain;
  logic             at_limit;
  logic             count_en;
  logic             unused_bits;

  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("tff_bank: WIDTH must be in 1..64");
    end
    if (MODE < 0 || MODE > 2) begin : g_bad_mode
      $error("tff_bank: MODE must be 0, 1 or 2");
    end
  endgenerate

  // Running AND of all lower bits: carry chain for counting up, borrow chain for counting down.
  assign ones_chain[0]  = 1'b1;
  assign zeros_chain[0] = 1'b1;
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
    assign ones_chain[gi+1]  = ones_chain[gi] & q_reg[gi];
    assign zeros_chain[gi+1] = zeros_chain[gi] & ~q_reg[gi];
  end

  assign at_limit = (IS_UP & ones_chain[WIDTH]) | (IS_DOWN & zeros_chain[WIDTH]);

`ifdef TFF_BANK_SAT_EN
  assign count_en = T[0] & ~at_limit;
`else
  assign count_en = T[0];
`endif

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_toggle
    if (MODE == 0) begin : g_bank
      assign t_vec[gi] = T[gi];
    end else if (MODE == 1) begin : g_up
      assign t_vec[gi] = count_en & ones_chain[gi];
    end else begin : g_down
      assign t_vec[gi] = count_en & zeros_chain[gi];
    end
  end

  always_comb begin
    q_next = q_reg;
    if (L) begin
      q_next = D;
    end else if (E) begin
      q_next = q_reg ^ t_vec;
    end
  end

  // TC is forced low while reset holds Q, even if RST_VAL happens to sit at the limit.
  always_comb begin
    TC = 1'b0;
    if (R) begin
`ifdef TFF_BANK_SAT_EN
      TC = ~L & at_limit;
`else
      TC = E & ~L & T[0] & at_limit;
`endif
    end
  end

  if (CLK_POL) begin : g_rise
    always_ff @(posedge C or negedge R) begin
      if (!R) begin
        q_reg <= RST_VAL;
      end else begin
        q_reg <= q_next;
      end
    end
  end else begin : g_fall
    always_ff @(negedge C or negedge R) begin
      if (!R) begin
        q_reg <= RST_VAL;
      end else begin
        q_reg <= q_next;
      end
    end
  end

  assign Q = q_reg;

  // Upper T bits and chain ends are meaningless in some modes.
  assign unused_bits = ^{T, ones_chain, zeros_chain, count_en, at_limit};

endmodule

// File: tb/tb_tff_bank.sv
// tb_tff_bank: directed checks of tff_bank in toggle, up, down and chained falling-edge configurations,
// compared every cycle against an arithmetic model of the register.
module tb_tff_bank;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       up_e, up_l, up_tc;
  logic [7:0] up_d, up_t, up_q;
  logic       tg_e, tg_l, tg_tc;
  logic [7:0] tg_d, tg_t, tg_q;
  logic       dn_e, dn_l, dn_tc;
  logic [7:0] dn_d, dn_t, dn_q;
  logic       ch_e, ch_l, ch_t0, lo_tc, hi_tc;
  logic [7:0] ch_d;
  logic [3:0] lo_q, hi_q;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_up, m_tg, m_dn, m_lo, m_hi;

  tff_bank #(.WIDTH(8), .MODE(1), .RST_VAL(8'h5A), .CLK_POL(1'b1)) u_up (
    .C(clk), .R(rst_n), .E(up_e), .L(up_l), .D(up_d), .T(up_t), .Q(up_q), .TC(up_tc));
  tff_bank #(.WIDTH(8), .MODE(0), .RST_VAL(8'h00), .CLK_POL(1'b1)) u_tg (
    .C(clk), .R(rst_n), .E(tg_e), .L(tg_l), .D(tg_d), .T(tg_t), .Q(tg_q), .TC(tg_tc));
  tff_bank #(.WIDTH(8), .MODE(2), .RST_VAL(8'hC3), .CLK_POL(1'b1)) u_dn (
    .C(clk), .R(rst_n), .E(dn_e), .L(dn_l), .D(dn_d), .T(dn_t), .Q(dn_q), .TC(dn_tc));
  tff_bank #(.WIDTH(4), .MODE(1), .RST_VAL(4'h0), .CLK_POL(1'b0)) u_lo (
    .C(clk), .R(rst_n), .E(ch_e), .L(ch_l), .D(ch_d[3:0]), .T({3'b101, ch_t0}), .Q(lo_q), .TC(lo_tc));
  tff_bank #(.WIDTH(4), .MODE(1), .RST_VAL(4'h0), .CLK_POL(1'b0)) u_hi (
    .C(clk), .R(rst_n), .E(lo_tc), .L(ch_l), .D(ch_d[7:4]), .T(4'b1011), .Q(hi_q), .TC(hi_tc));

  // Next register value from the behavioural rules: load, hold, xor-mask, or +/- T[0] modulo 2^w.
  function automatic logic [7:0] f_next(input int w, input int mode, input logic [7:0] q,
                                        input logic [7:0] d, input logic [7:0] t,
                                        input logic l, input logic e);
    logic [7:0] top;
    top = 8'((16'd1 << w) - 16'd1);
    if (l) return d & top;
    if (!e) return q;
    if (mode == 0) return q ^ t;
`ifdef TFF_BANK_SAT_EN
    if (mode == 1 && q == top) return q;
    if (mode == 2 && q == 8'd0) return q;
`endif
    if (mode == 1) return (q + {7'd0, t[0]}) & top;
    return (q - {7'd0, t[0]}) & top;
  endfunction

  function automatic logic f_tc(input int w, input int mode, input logic [7:0] q,
                                input logic rst, input logic l, input logic e, input logic t0);
    logic at_lim;
    at_lim = (mode == 1) ? (q == 8'((16'd1 << w) - 16'd1)) : (q == 8'd0);
    if (!rst || mode == 0) return 1'b0;
`ifdef TFF_BANK_SAT_EN
    return !l && at_lim;
`else
    return !l && e && t0 && at_lim;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_up <= 8'h5A;
      m_tg <= 8'h00;
      m_dn <= 8'hC3;
    end else begin
      m_up <= f_next(8, 1, m_up, up_d, up_t, up_l, up_e);
      m_tg <= f_next(8, 0, m_tg, tg_d, tg_t, tg_l, tg_e);
      m_dn <= f_next(8, 2, m_dn, dn_d, dn_t, dn_l, dn_e);
    end
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lo <= 8'h00;
      m_hi <= 8'h00;
    end else begin
      m_lo <= f_next(4, 1, m_lo, {4'd0, ch_d[3:0]}, {7'd0, ch_t0}, ch_l, ch_e);
      m_hi <= f_next(4, 1, m_hi, {4'd0, ch_d[7:4]}, 8'h01, ch_l,
                     f_tc(4, 1, m_lo, 1'b1, ch_l, ch_e, ch_t0));
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] req);
    $display("txn %-10s q=%h expect=%h", name, act, req);
    chk(name, act, req);
  endtask

  // Rising-edge instances are compared on the falling edge, the falling-edge chain just after the rising edge.
  always @(negedge clk) begin
    chk("up_q", up_q, m_up);
    chk("up_tc", {7'd0, up_tc}, {7'd0, f_tc(8, 1, m_up, rst_n, up_l, up_e, up_t[0])});
    chk("tg_q", tg_q, m_tg);
    chk("tg_tc", {7'd0, tg_tc}, {7'd0, f_tc(8, 0, m_tg, rst_n, tg_l, tg_e, tg_t[0])});
    chk("dn_q", dn_q, m_dn);
    chk("dn_tc", {7'd0, dn_tc}, {7'd0, f_tc(8, 2, m_dn, rst_n, dn_l, dn_e, dn_t[0])});
  end

  always @(posedge clk) begin
    #2;
    chk("ch_q", {hi_q, lo_q}, {m_hi[3:0], m_lo[3:0]});
    chk("lo_tc", {7'd0, lo_tc}, {7'd0, f_tc(4, 1, m_lo, rst_n, ch_l, ch_e, ch_t0)});
    chk("hi_tc", {7'd0, hi_tc},
        {7'd0, f_tc(4, 1, m_hi, rst_n, ch_l, f_tc(4, 1, m_lo, rst_n, ch_l, ch_e, ch_t0), 1'b1)});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    up_e = 0; up_l = 0; up_d = 0; up_t = 0;
    tg_e = 0; tg_l = 0; tg_d = 0; tg_t = 0;
    dn_e = 0; dn_l = 0; dn_d = 0; dn_t = 0;
    ch_e = 0; ch_l = 0; ch_t0 = 0; ch_d = 0;
    #12;
    lit("rst_up_q", up_q, 8'h5A);
    lit("rst_up_tc", {7'd0, up_tc}, 8'h00);
    lit("rst_dn_q", dn_q, 8'hC3);
    step();
    rst_n = 1'b1;

    // toggle bank
    tg_e = 1; tg_t = 8'hA5;
    step(); lit("tg_1", tg_q, 8'hA5);
    step(); lit("tg_2", tg_q, 8'h00);
    tg_e = 0; tg_t = 8'hFF;
    step(); lit("tg_hold", tg_q, 8'h00);
    lit("tg_tc", {7'd0, tg_tc}, 8'h00);

    // reset asserted mid-count
    up_l = 1; up_d = 8'h0E;
    step();
    up_l = 0; up_e = 1; up_t = 8'hF1;
    step(); step(); lit("up_10", up_q, 8'h10);
    #2 rst_n = 1'b0;
    #1 lit("mid_rst_q", up_q, 8'h5A);
    lit("mid_rst_tc", {7'd0, up_tc}, 8'h00);
    step();
    rst_n = 1'b1;
    step(); step(); step();
    lit("up_5d", up_q, 8'h5D);

    // up wrap
    up_l = 1; up_d = 8'hFE;
    step(); lit("up_fe", up_q, 8'hFE);
    up_l = 0;
    step(); lit("up_ff", up_q, 8'hFF);
    lit("up_ff_tc", {7'd0, up_tc}, 8'h01);
    step();
`ifdef TFF_BANK_SAT_EN
    lit("up_sat", up_q, 8'hFF);
    lit("up_sat_tc", {7'd0, up_tc}, 8'h01);
`else
    lit("up_wrap", up_q, 8'h00);
    lit("up_wrap_tc", {7'd0, up_tc}, 8'h00);
`endif

    // load priority
    up_l = 1; up_d = 8'hFF;
    step(); lit("ld_ff", up_q, 8'hFF);
    up_d = 8'h33;
    #1 lit("ld_tc", {7'd0, up_tc}, 8'h00);
    step(); lit("ld_33", up_q, 8'h33);
    up_e = 0; up_d = 8'h77;
    step(); lit("ld_noe", up_q, 8'h77);
    up_l = 0;
    step(); lit("up_hold", up_q, 8'h77);

    // down wrap
    dn_l = 1; dn_d = 8'h01;
    step(); lit("dn_01", dn_q, 8'h01);
    dn_l = 0; dn_e = 1; dn_t = 8'h81;
    lit("dn_01_tc", {7'd0, dn_tc}, 8'h00);
    step(); lit("dn_00", dn_q, 8'h00);
    lit("dn_00_tc", {7'd0, dn_tc}, 8'h01);
    step();
`ifdef TFF_BANK_SAT_EN
    lit("dn_sat", dn_q, 8'h00);
    dn_t = 8'hFE;
    step(); lit("dn_hold", dn_q, 8'h00);
    lit("dn_hold_tc", {7'd0, dn_tc}, 8'h01);
`else
    lit("dn_wrap", dn_q, 8'hFF);
    lit("dn_wrap_tc", {7'd0, dn_tc}, 8'h00);
    dn_t = 8'hFE;
    step(); lit("dn_hold", dn_q, 8'hFF);
    lit("dn_hold_tc", {7'd0, dn_tc}, 8'h00);
`endif

    // falling-edge chained 8-bit counter
    ch_l = 1; ch_d = 8'h00;
    step();
    ch_l = 0; ch_e = 1; ch_t0 = 1;
    for (int i = 1; i <= 256; i++) begin
      step();
      if (i == 15) begin
        lit("ch_0f", {hi_q, lo_q}, 8'h0F);
        lit("ch_0f_tc", {7'd0, lo_tc}, 8'h01);
      end
`ifndef TFF_BANK_SAT_EN
      if (i == 8'h37) lit("ch_37", {hi_q, lo_q}, 8'h37);
`endif
    end
`ifdef TFF_BANK_SAT_EN
    lit("ch_end", {hi_q, lo_q}, 8'hFF);
`else
    lit("ch_end", {hi_q, lo_q}, 8'h00);
`endif
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tff_bank.md
Name: tff_bank

Overview:
- Parametrised multi-bit toggle-flop register built from per-bit T-flop cells: each bit's next state is Q XOR t_i.
- Three modes selected by parameter:
  - independent toggle bank (per-bit toggle mask),
  - synchronous up counter,
  - synchronous down counter.
- In the counter modes t_i is the carry/borrow chain.
- Adds load, enable, configurable clock edge, reset value and a terminal-count strobe.
- Sits in the techmap library as the wide replacement for chains of single-bit T-flops, used by counter and divider inference.

Parameters:
- WIDTH, 8, number of flop bits; legal range 1..64.
- MODE, 0, 0 = toggle bank, 1 = up counter, 2 = down counter; any other value is a elaboration error.
- RST_VAL, 0, WIDTH-bit value loaded into Q on reset.
- CLK_POL, 1, 1 = rising-edge clocking, 0 = falling-edge clocking.

Ports:
- C  input  1  clock; active edge set by CLK_POL.
- R  input  1  asynchronous reset, active-low.
- E  input  1  clock enable, active-high.
- L  input  1  synchronous load, active-high.
- D  input  WIDTH  load value.
- T  input  WIDTH  toggle mask in MODE 0; in MODE 1/2 only T[0] is used, as count enable / carry-in, and T[WIDTH-1:1] are ignored.
- Q  output  WIDTH  register state.
- TC  output  1  terminal count, combinational.

Behaviour:
- Reset:
  - R low forces Q = RST_VAL immediately, independent of C.
  - Q holds RST_VAL while R is low; all other inputs are ignored.
  - First update occurs on the first active edge after R rises.
- Priority at the active edge: L > (E & toggle) > hold.
  - L=1: Q <= D. This applies regardless of E.
  - L=0, E=0: Q holds.
  - L=0, E=1: Q <= Q ^ t.
- Toggle vector t:
  - MODE 0: t = T.
  - MODE 1: t_0 = T[0]; t_i = T[0] & (&Q[i-1:0]). Result is Q + T[0] mod 2^WIDTH; all-ones wraps to 0.
  - MODE 2: t_0 = T[0]; t_i = T[0] & (&~Q[i-1:0]). Result is Q - T[0] mod 2^WIDTH; 0 wraps to all-ones.
- TC:
  - MODE 0: TC = 0.
  - MODE 1: TC = E & ~L & T[0] & (Q == all-ones).
  - MODE 2: TC = E & ~L & T[0] & (Q == 0).
  - TC is high in the cycle before the wrapping edge, so it can chain into the next stage's T[0]/E. It is 0 during reset.
- Single-cycle update latency: Q reflects an input on the active edge it was sampled at.
- Simultaneous L and terminal condition: the load wins, TC = 0 and no wrap occurs.
- WIDTH=1: MODE 1 and MODE 2 both reduce to a plain T-flop, and TC = E & ~L & T[0] & (Q == 1 for up, 0 for down).
- Reset asserted mid-count aborts immediately; no partial update of any bit.

Optional Feature:
- Macro: TFF_BANK_SAT_EN.
- Defined:
  - MODE 1 saturates at all-ones and MODE 2 saturates at 0: t is forced to 0 when at the limit, so Q holds.
  - TC = ~L & (Q == limit), held high for as long as Q sits at the limit, independent of E and T[0].
  - Load still overrides.
  - MODE 0 is unchanged.
- Not defined: wrap-around behaviour and strobe TC as above.

Test Plan:
- Reset: MODE 1, RST_VAL=8'h5A, R low mid-count at Q=8'h10 -> Q=8'h5A immediately without a clock edge, TC=0; after R rises, 3 enabled edges with T[0]=1 -> Q=8'h5D.
- Toggle bank: MODE 0, Q=8'h00, E=1, T=8'hA5 for 2 edges -> Q=8'hA5 then 8'h00; with E=0 and T=8'hFF -> Q unchanged; TC stays 0.
- Up wrap: MODE 1, L=1 D=8'hFE, then E=1 T[0]=1 -> Q=8'hFF with TC=1 during that cycle, next edge Q=8'h00 with TC=0; with TFF_BANK_SAT_EN -> Q stays 8'hFF and TC stays 1.
- Down wrap: MODE 2, Q=8'h01 -> 8'h00 (TC=1) -> 8'hFF; with T[0]=0 and E=1 -> hold.
- Load priority: MODE 1, Q=8'hFF, E=1, T[0]=1, L=1, D=8'h33 -> TC=0 in that cycle, Q=8'h33 after the edge; L=1 with E=0 -> load still occurs.
- Clock polarity and chaining: CLK_POL=0, two WIDTH=4 MODE 1 instances with TC of the low instance driving E of the high one -> updates only on falling edges; counts 0x00..0xFF as an 8-bit counter and wraps to 0x00 after 256 enabled edges.
